pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl_if.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 61 ++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-unit operands from ID/EX and the stage-control strobes and counters it returns.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic use_rs_id;
  logic use_rt_id;
  logic MemRead_id_ex;
  logic [4:0] regfile_write_num_id_ex;
  logic branch_taken_ex;
  logic halt_req_ex;
  logic resume;
  logic pc_stall;
  logic if_id_stall;
  logic nop_lock_id;
  logic pc_bj;
  logic halt_ex;
  logic halted;
  logic [1:0] state_o;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output rs_id, rt_id, use_rs_id, use_rt_id, MemRead_id_ex, regfile_write_num_id_ex,
           branch_taken_ex, halt_req_ex, resume,
    input  pc_stall, if_id_stall, nop_lock_id, pc_bj, halt_ex, halted, state_o,
           cycle_cnt, stall_cnt, flush_cnt
  );
  modport slave (
    input  rs_id, rt_id, use_rs_id, use_rt_id, MemRead_id_ex, regfile_write_num_id_ex,
           branch_taken_ex, halt_req_ex, resume,
    output pc_stall, if_id_stall, nop_lock_id, pc_bj, halt_ex, halted, state_o,
           cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush and syscall-halt sequencing for the 5-stage MIPS core.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;
  state_t state, nxt;
  logic [3:0] dcnt, dcnt_nxt;
  logic [CNT_W-1:0] cyc, stl, fl;
  logic lu, run, halt_go, br, stall;
  assign lu = bus.MemRead_id_ex && bus.regfile_write_num_id_ex != 5'd0 &&
              ((bus.use_rs_id && bus.rs_id == bus.regfile_write_num_id_ex) ||
               (bus.use_rt_id && bus.rt_id == bus.regfile_write_num_id_ex));
  // the unused encoding behaves as RUN so a corrupted state recovers cleanly
  assign run = state != DRAIN && state != HALTED;
  assign halt_go = run && bus.halt_req_ex;
  assign br = run && !bus.halt_req_ex && bus.branch_taken_ex;
  assign stall = run && !bus.halt_req_ex && !bus.branch_taken_ex && lu;
  assign bus.pc_stall = halt_go || stall || !run;
  assign bus.if_id_stall = halt_go || stall || !run;
  assign bus.nop_lock_id = halt_go || stall || state == DRAIN;
  assign bus.pc_bj = br;
  assign bus.halt_ex = state == HALTED;
  assign bus.halted = state == HALTED;
  assign bus.state_o = state;
  assign bus.cycle_cnt = cyc;
  assign bus.stall_cnt = stl;
  assign bus.flush_cnt = fl;
  always_comb begin
    nxt = RUN;
    dcnt_nxt = dcnt;
    if (halt_go) begin
      nxt = DRAIN;
      dcnt_nxt = 4'(DRAIN_CYCLES - 1);
    end else if (state == DRAIN) begin
      nxt = dcnt == 4'd0 ? HALTED : DRAIN;
      dcnt_nxt = dcnt == 4'd0 ? 4'd0 : dcnt - 4'd1;
    end else if (state == HALTED) begin
      nxt = bus.resume ? RUN : HALTED;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      dcnt <= 4'd0;
      cyc <= '0;
      stl <= '0;
      fl <= '0;
    end else begin
      state <= nxt;
      dcnt <= dcnt_nxt;
      cyc <= cyc + CNT_W'(run && cyc != '1);
      stl <= stl + CNT_W'(stall && stl != '1);
      fl <= fl + CNT_W'(br && fl != '1);
    end
  end
endmodule
